// File: rtl/cp0_ctrl.sv
// MIPS-style coprocessor-0 control block: Status/Cause/EPC/BadVAddr, exception and ERET
// bookkeeping, and interrupt request generation. Define CP0_TIMER_EN to build Count/Compare/TI.
module cp0_ctrl #(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mtc0_we,
  input  logic [4:0]            waddr,
  input  logic [4:0]            raddr,
  input  logic [31:0]           wdata,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  exc_bd,
  input  logic                  eret,
  output logic [31:0]           rdata,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_req
);

  localparam logic [31:0] STATUS_RST = 32'h00400000;

  // exc_valid and eret are single-cycle commit pulses with no back-pressure:
  // the block accepts every pulse on the clock edge where it is high.
  logic [7:0]  im;
  logic        exl, ie;
  logic        bd;
  logic [5:0]  hw_ip, hw_ip_next;
  logic [1:0]  sw_ip;
  logic [4:0]  exc_code_r;
  logic [31:0] epc, badvaddr;
  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;

  logic wr_status, wr_cause, wr_epc;
  assign wr_status = mtc0_we && (waddr == 5'd12);
  assign wr_cause  = mtc0_we && (waddr == 5'd13);
  assign wr_epc    = mtc0_we && (waddr == 5'd14);

  always_comb begin
    hw_ip_next                 = '0;
    hw_ip_next[NUM_HW_INT-1:0] = int_i;
  end

  // The timer interrupt shares IP[7] with the highest hardware line.
  assign ip       = {hw_ip[5] | ti, hw_ip[4:0], sw_ip};
  assign status_o = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign cause_o  = {bd, ti, 14'b0, ip, 1'b0, exc_code_r, 2'b0};
  assign epc_o    = epc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      hw_ip      <= '0;
      sw_ip      <= '0;
      exc_code_r <= '0;
      epc        <= '0;
      badvaddr   <= '0;
      int_req    <= 1'b0;
    end else begin
      hw_ip <= hw_ip_next;
      if (wr_status) begin
        im <= wdata[15:8];
        ie <= wdata[0];
      end
      if (exc_valid)      exl <= 1'b1;
      else if (eret)      exl <= 1'b0;
      else if (wr_status) exl <= wdata[1];
      if (wr_cause) sw_ip <= wdata[9:8];
      if (exc_valid) begin
        exc_code_r <= exc_code;
        if (!exl) bd <= exc_bd;
        if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr <= exc_badvaddr;
      end
      // A nested exception keeps the EPC of the outermost one.
      if (exc_valid && !exl) epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
      else if (wr_epc)       epc <= wdata;
      int_req <= ie & ~exl & (|(ip & im));
    end
  end

`ifdef CP0_TIMER_EN
  logic        tick;
  logic [31:0] count_inc;
  logic        wr_count, wr_compare;
  assign wr_count   = mtc0_we && (waddr == 5'd9);
  assign wr_compare = mtc0_we && (waddr == 5'd11);
  assign count_inc  = count + 32'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count   <= '0;
      compare <= '0;
      tick    <= 1'b0;
      ti      <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= wdata;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count_inc;
      end
      if (wr_compare) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (!wr_count && tick && count_inc == compare) begin
        ti <= 1'b1;
      end
    end
  end
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  // While in reset, reads return reset values even before the first clock edge.
  always_comb begin
    rdata = '0;
    if (!resetn) begin
      case (raddr)
        5'd12:   rdata = STATUS_RST;
        5'd15:   rdata = PRID_VAL;
        5'd16:   rdata = CONFIG_VAL;
        default: rdata = '0;
      endcase
    end else begin
      case (raddr)
        5'd8:    rdata = badvaddr;
        5'd9:    rdata = count;
        5'd11:   rdata = compare;
        5'd12:   rdata = status_o;
        5'd13:   rdata = cause_o;
        5'd14:   rdata = epc;
        5'd15:   rdata = PRID_VAL;
        5'd16:   rdata = CONFIG_VAL;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed self-checking bench for cp0_ctrl; timer checks follow the CP0_TIMER_EN build option.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mtc0_we;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [5:0]  int_i;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;
  logic        exc_bd;
  logic        eret;
  logic [31:0] rdata, status_o, cause_o, epc_o;
  logic        int_req;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] d;

  cp0_ctrl dut (
    .clk(clk), .resetn(resetn), .mtc0_we(mtc0_we), .waddr(waddr), .raddr(raddr),
    .wdata(wdata), .int_i(int_i), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr), .exc_bd(exc_bd), .eret(eret),
    .rdata(rdata), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .int_req(int_req)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    raddr = a;
    #1;
    v = rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
    mtc0_we = 1'b1;
    waddr   = a;
    wdata   = v;
    @(negedge clk);
    mtc0_we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bdv,
                     input logic [31:0] bva);
    exc_valid    = 1'b1;
    exc_code     = code;
    exc_pc       = pc;
    exc_bd       = bdv;
    exc_badvaddr = bva;
    @(negedge clk);
    exc_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; mtc0_we = 1'b0; waddr = '0; raddr = '0; wdata = '0; int_i = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_badvaddr = '0; exc_bd = 1'b0;
    eret = 1'b0;

    // Reset values and reads during reset
    repeat (3) @(negedge clk);
    rd(5'd12, d); check("rst_status_rd", d, 32'h00400000);
    rd(5'd15, d); check("rst_prid", d, 32'h004C0102);
    rd(5'd16, d); check("rst_config", d, 32'h00008000);
    rd(5'd13, d); check("rst_cause_rd", d, 32'h0);
    check("rst_status_o", status_o, 32'h00400000);
    check("rst_epc_o", epc_o, 32'h0);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    rd(5'd7, d); check("unmapped_rd", d, 32'h0);

    // Writable-bit masks
    mtc0(5'd12, 32'hFFFFFFFF);
    check("status_mask", status_o, 32'h0040FF03);
    mtc0(5'd12, 32'h0);
    check("status_clear", status_o, 32'h00400000);
    mtc0(5'd13, 32'hFFFFFFFF);
    check("cause_mask", cause_o, 32'h00000300);
    mtc0(5'd13, 32'h0);
    mtc0(5'd15, 32'h0);
    rd(5'd15, d); check("prid_ro", d, 32'h004C0102);
    mtc0(5'd14, 32'h12345678);
    rd(5'd14, d); check("epc_wr", d, 32'h12345678);

    // Hardware interrupt path
    mtc0(5'd12, 32'h00000401);
    int_i = 6'b000001;
    @(negedge clk);
    check("ip2_after1", {31'b0, cause_o[10]}, 32'h1);
    check("int_req_lat1", {31'b0, int_req}, 32'h0);
    @(negedge clk);
    check("int_req_lat2", {31'b0, int_req}, 32'h1);
    mtc0(5'd12, 32'h00000403);
    @(negedge clk);
    check("int_req_exl", {31'b0, int_req}, 32'h0);
    int_i = '0;
    mtc0(5'd12, 32'h0);
    @(negedge clk);

    // Exception in delay slot with address error
    exc(5'd4, 32'hBFC00100, 1'b1, 32'h00001003);
    check("exc1_epc", epc_o, 32'hBFC000FC);
    check("exc1_cause", cause_o, 32'h80000010);
    rd(5'd8, d); check("exc1_badvaddr", d, 32'h00001003);
    check("exc1_status", status_o, 32'h00400002);

    // Nested exception keeps EPC/BD, updates ExcCode, no BadVAddr load
    exc(5'd8, 32'h00001234, 1'b0, 32'h00005555);
    check("exc2_epc", epc_o, 32'hBFC000FC);
    check("exc2_cause", cause_o, 32'h80000020);
    rd(5'd8, d); check("exc2_badvaddr", d, 32'h00001003);

    // ERET beats mtc0 on EXL; IE still written
    eret = 1'b1;
    mtc0(5'd12, 32'h00000003);
    eret = 1'b0;
    check("eret_mtc0", status_o, 32'h00400001);

    // Exception beats ERET
    eret = 1'b1;
    exc(5'd0, 32'h00000100, 1'b0, 32'h0);
    eret = 1'b0;
    check("exc_over_eret", status_o, 32'h00400003);
    check("exc3_epc", epc_o, 32'h00000100);
    check("exc3_cause", cause_o, 32'h0);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    check("eret_only", status_o, 32'h00400001);

`ifdef CP0_TIMER_EN
    mtc0(5'd12, 32'h00008001);
    mtc0(5'd9, 32'h00000100);
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 40 && !cause_o[30]; i++) @(negedge clk);
    check("ti_set", {31'b0, cause_o[30]}, 32'h1);
    rd(5'd9, d); check("count_at_match", d, 32'd10);
    check("ip7_ti", {31'b0, cause_o[15]}, 32'h1);
    check("timer_int_req_lat1", {31'b0, int_req}, 32'h0);
    @(negedge clk);
    check("timer_int_req", {31'b0, int_req}, 32'h1);
    mtc0(5'd11, 32'h00001000);
    check("ti_clear", {31'b0, cause_o[30]}, 32'h0);
    check("ip7_clear", {31'b0, cause_o[15]}, 32'h0);
    mtc0(5'd9, 32'h00000055);
`else
    mtc0(5'd9, 32'd5);
    mtc0(5'd11, 32'd7);
    rd(5'd9, d); check("count_off", d, 32'h0);
    rd(5'd11, d); check("compare_off", d, 32'h0);
    repeat (30) @(negedge clk);
    check("ti_off", {31'b0, cause_o[30]}, 32'h0);
`endif

    // Reset mid-operation with pending write, exception and eret
    resetn = 1'b0;
    mtc0_we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD0000;
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h00002000; exc_bd = 1'b0;
    exc_badvaddr = 32'h00009999; eret = 1'b1;
    @(negedge clk);
    mtc0_we = 1'b0; exc_valid = 1'b0; eret = 1'b0;
    check("mid_rst_status", status_o, 32'h00400000);
    check("mid_rst_cause", cause_o, 32'h0);
    check("mid_rst_epc", epc_o, 32'h0);
    check("mid_rst_int_req", {31'b0, int_req}, 32'h0);
    resetn = 1'b1;
    rd(5'd8, d); check("mid_rst_badvaddr", d, 32'h0);
    rd(5'd9, d); check("mid_rst_count", d, 32'h0);
    rd(5'd11, d); check("mid_rst_compare", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have parameter NUM_HW_INT, default 6, meaning the number of hardware interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2].
REQ-002 SHALL have parameter PRID_VAL, default 32'h004C0102, meaning the PRId read value.
REQ-003 SHALL have parameter CONFIG_VAL, default 32'h00008000, meaning the Config read value.
REQ-004 SHALL have port clk  in  1  clock, with all state updated on posedge clk.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port mtc0_we  in  1  CP0 write strobe.
REQ-007 SHALL have port waddr / raddr  in  5  write / read register number.
REQ-008 SHALL have port wdata  in  32  write data.
REQ-009 SHALL have port int_i  in  NUM_HW_INT  level-sensitive hardware interrupts.
REQ-010 SHALL have port exc_valid  in  1  exception commit, one-cycle pulse.
REQ-011 SHALL have port exc_code  in  5  ExcCode.
REQ-012 SHALL have port exc_pc / exc_badvaddr  in  32  faulting PC / faulting address.
REQ-013 SHALL have port exc_bd  in  1  faulting instruction is in a delay slot.
REQ-014 SHALL have port eret  in  1  ERET commit pulse.
REQ-015 SHALL have port rdata  out  32  combinational read data.
REQ-016 SHALL have port status_o / cause_o / epc_o  out  32  live register values.
REQ-017 SHALL have port int_req  out  1  registered interrupt request to the pipeline.

Function
REQ-018 SHALL implement registers BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16; any other raddr SHALL read 0.
REQ-019 SHALL limit writable bits to Status[15:8] (IM), Status[1] (EXL), Status[0] (IE), Cause[9:8] (software IP), full EPC, Count and Compare; writes to other bits or registers SHALL be ignored.
REQ-020 SHALL sample int_i into Cause.IP[2+k] every cycle (one-cycle latency) and SHALL clear unused IP bits to 0.
REQ-021 SHALL increment Count once every two clk cycles using an internal toggle bit, and SHALL wrap 0xFFFFFFFF to 0.
REQ-022 SHALL set Cause.TI (bit 30) on the cycle Count==Compare after an increment, SHALL hold it until a Compare write clears it, and SHALL OR TI into Cause.IP[7].
REQ-023 SHALL compute int_req, registered one cycle, as Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
REQ-024 SHALL handle exc_valid as follows: set EXL and write ExcCode into Cause[6:2]; if EXL was 0, EPC = exc_bd ? exc_pc-4 : exc_pc and Cause.BD = exc_bd; if EXL was already 1, leave EPC and BD unchanged.
REQ-025 SHALL load BadVAddr from exc_badvaddr only for ExcCode 4 (AdEL) or 5 (AdES).
REQ-026 SHALL clear Status.EXL on eret.
REQ-027 SHALL give exc_valid priority over eret, and eret priority over mtc0_we to the same field in the same cycle; mtc0 writes to unaffected fields SHALL still apply.
REQ-028 SHALL give a Count write priority over the increment, and SHALL also clear the toggle bit on a Count write.
REQ-029 SHALL give a Compare write in the same cycle as a match priority, leaving TI at 0.

Reset
REQ-030 SHALL, on resetn=0 at posedge clk, set Status=32'h00400000 (BEV=1) and set Cause, EPC, BadVAddr, Count, Compare, the toggle bit and int_req to 0.
REQ-031 SHALL drive rdata from the reset values during reset.
REQ-032 SHALL, when reset is asserted mid-operation, abandon any pending exc_valid, eret or write that cycle.

Configuration
REQ-033 SHALL, with macro CP0_TIMER_EN defined, implement Count, Compare and TI as above.
REQ-034 SHALL, without CP0_TIMER_EN, read Count and Compare as 0, ignore writes to them, hold TI at 0 and infer no counter logic.

Verification
REQ-035 SHALL cover: write Compare=10, Count=0 -> TI=1 and Cause.IP[7]=1 after about 20 cycles; with IE=1 and IM[7]=1, int_req=1 one cycle later; a Compare write clears TI.
REQ-036 SHALL cover: exc_valid with code 4, exc_pc=0xBFC00100, exc_bd=1, badvaddr=0x1003 -> EPC=0xBFC000FC, Cause.BD=1, ExcCode=4, BadVAddr=0x1003, EXL=1.
REQ-037 SHALL cover: a second exception (code 8) while EXL=1 -> EPC unchanged and ExcCode=8.
REQ-038 SHALL cover: eret and mtc0 Status=0x00000003 in the same cycle -> EXL=0 and IE=1.
REQ-039 SHALL cover: int_i[0]=1 with IM[2]=1 and IE=1 -> Cause.IP[2]=1 after 1 cycle and int_req=1 after 2 cycles; with EXL=1, int_req=0.
REQ-040 SHALL cover: resetn=0 mid-count -> Status=0x00400000 and all other registers 0 on the next cycle.
